// File: rtl/bt656_stream_tx.sv
// BT.656 transmitter: free-running progressive line/frame timing with embedded EAV/SAV codes,
// fed from an AXI4-Stream 4:2:2 pixel source through a one-entry holding register.
module bt656_stream_tx #(
  parameter int H_ACTIVE = 720,
  parameter int H_BLANK  = 268,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        enable_i,
  input  logic        err_clr_i,
  input  logic [15:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tuser,
  input  logic        s_tlast,
  output logic [7:0]  bt656_data_o,
  output logic        synced_o,
  output logic        underrun_o,
  output logic        sof_err_o,
  output logic        eol_err_o
);

  localparam int LINE_LEN = 8 + H_BLANK + 2 * H_ACTIVE;
  localparam int LINES    = V_ACTIVE + V_BLANK;
  localparam int BW       = $clog2(LINE_LEN);
  localparam int LW       = $clog2(LINES);

  localparam logic [BW-1:0] B_LAST  = BW'(LINE_LEN - 1);
  localparam logic [BW-1:0] B_SAV0  = BW'(4 + H_BLANK);
  localparam logic [BW-1:0] B_SAV1  = BW'(5 + H_BLANK);
  localparam logic [BW-1:0] B_SAV2  = BW'(6 + H_BLANK);
  localparam logic [BW-1:0] B_SAV3  = BW'(7 + H_BLANK);
  localparam logic [BW-1:0] B_DATA  = BW'(8 + H_BLANK);
  localparam logic [BW-1:0] B_LASTC = BW'(LINE_LEN - 2);
  localparam logic [LW-1:0] L_LAST  = LW'(LINES - 1);
  localparam logic [LW-1:0] L_BLANK = LW'(V_ACTIVE);

  typedef enum logic {UNSYNCED = 1'b0, SYNCED = 1'b1} sync_state_e;

  sync_state_e   state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    yhold_q, yhold_d;
  logic [15:0]   pix_q, pix_d;
  logic          pix_user_q, pix_user_d;
  logic          pix_last_q, pix_last_d;
  logic          pix_valid_q, pix_valid_d;
  logic          underrun_q, underrun_d;
  logic          sof_err_q, sof_err_d;
  logic          eol_err_q, eol_err_d;

  logic active_line, c_slot, first_px, last_px;
  logic consume, discard, underrun_ev, sof_ev, eol_ev, handshake;

  function automatic logic [7:0] clamp(input logic [7:0] b);
    if (b == 8'h00)      return 8'h01;
    else if (b == 8'hFF) return 8'hFE;
    else                 return b;
  endfunction

  // Data starts at an even byte offset, so even offsets in the data region are C slots.
  assign active_line = (lcnt_q < L_BLANK);
  assign c_slot      = enable_i & active_line & (bcnt_q >= B_DATA) & ~bcnt_q[0];
  assign first_px    = (lcnt_q == '0) & (bcnt_q == B_DATA);
  assign last_px     = (bcnt_q == B_LASTC);

  always_comb begin
    state_d     = state_q;
    consume     = 1'b0;
    discard     = 1'b0;
    underrun_ev = 1'b0;
    sof_ev      = 1'b0;
    eol_ev      = 1'b0;
    if (c_slot) begin
      case (state_q)
        UNSYNCED: begin
          if (first_px && pix_valid_q && pix_user_q) begin
            consume = 1'b1;
            state_d = SYNCED;
          end
        end
        SYNCED: begin
          if (!pix_valid_q) begin
            underrun_ev = 1'b1;
          end else if (pix_user_q && !first_px) begin
            sof_ev  = 1'b1;
            state_d = UNSYNCED;
          end else if (!pix_user_q && first_px) begin
            sof_ev  = 1'b1;
            discard = 1'b1;
            state_d = UNSYNCED;
          end else begin
            consume = 1'b1;
          end
        end
        default: state_d = UNSYNCED;
      endcase
    end
    if (consume) eol_ev = last_px ? ~pix_last_q : pix_last_q;
    if (!enable_i) state_d = UNSYNCED;
  end

  assign s_tready  = ARESETn & enable_i & (~pix_valid_q | consume);
  assign handshake = s_tvalid & s_tready;

  // While hunting for frame start only SOF beats are kept; everything else is dropped.
  always_comb begin
    pix_d       = pix_q;
    pix_user_d  = pix_user_q;
    pix_last_d  = pix_last_q;
    pix_valid_d = pix_valid_q;
    if (consume || discard) pix_valid_d = 1'b0;
    if (handshake && (state_d == SYNCED || s_tuser)) begin
      pix_d       = s_tdata;
      pix_user_d  = s_tuser;
      pix_last_d  = s_tlast;
      pix_valid_d = 1'b1;
    end
    if (!enable_i) pix_valid_d = 1'b0;
  end

  always_comb begin
    bcnt_d = bcnt_q;
    lcnt_d = lcnt_q;
    if (!enable_i) begin
      bcnt_d = '0;
      lcnt_d = L_BLANK;
    end else if (bcnt_q == B_LAST) begin
      bcnt_d = '0;
      lcnt_d = (lcnt_q == L_LAST) ? '0 : lcnt_q + LW'(1);
    end else begin
      bcnt_d = bcnt_q + BW'(1);
    end
  end

  always_comb begin
    data_d  = 8'h10;
    yhold_d = yhold_q;
    if (c_slot) yhold_d = consume ? clamp(pix_q[7:0]) : 8'h10;
    if (enable_i) begin
      if (bcnt_q == '0 || bcnt_q == B_SAV0) begin
        data_d = 8'hFF;
      end else if (bcnt_q == BW'(1) || bcnt_q == BW'(2) || bcnt_q == B_SAV1 || bcnt_q == B_SAV2) begin
        data_d = 8'h00;
      end else if (bcnt_q == BW'(3)) begin
        data_d = active_line ? 8'h9D : 8'hB6;
      end else if (bcnt_q == B_SAV3) begin
        data_d = active_line ? 8'h80 : 8'hAB;
      end else if (active_line && bcnt_q >= B_DATA) begin
        data_d = bcnt_q[0] ? yhold_q : (consume ? clamp(pix_q[15:8]) : 8'h80);
      end else begin
        data_d = bcnt_q[0] ? 8'h10 : 8'h80;
      end
    end
  end

  assign underrun_d = (underrun_q & ~err_clr_i) | underrun_ev;
  assign sof_err_d  = (sof_err_q & ~err_clr_i) | sof_ev;
  assign eol_err_d  = (eol_err_q & ~err_clr_i) | eol_ev;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= UNSYNCED;
      bcnt_q      <= '0;
      lcnt_q      <= L_BLANK;
      data_q      <= 8'h10;
      yhold_q     <= 8'h10;
      pix_q       <= '0;
      pix_user_q  <= 1'b0;
      pix_last_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      sof_err_q   <= 1'b0;
      eol_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      lcnt_q      <= lcnt_d;
      data_q      <= data_d;
      yhold_q     <= yhold_d;
      pix_q       <= pix_d;
      pix_user_q  <= pix_user_d;
      pix_last_q  <= pix_last_d;
      pix_valid_q <= pix_valid_d;
      underrun_q  <= underrun_d;
      sof_err_q   <= sof_err_d;
      eol_err_q   <= eol_err_d;
    end
  end

  assign bt656_data_o = data_q;
  assign synced_o     = (state_q == SYNCED);
  assign underrun_o   = underrun_q;
  assign sof_err_o    = sof_err_q;
  assign eol_err_o    = eol_err_q;

endmodule

// File: tb/tb_bt656_stream_tx.sv
// Bench for bt656_stream_tx: drives AXI beats from a queue and compares every output byte
// against a frame-level byte model built from slot contents.
module tb_bt656_stream_tx;

  localparam int HA = 4;
  localparam int HB = 4;
  localparam int VA = 2;
  localparam int VB = 1;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        enable_i;
  logic        err_clr_i;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tuser;
  logic        s_tlast;
  logic [7:0]  bt656_data_o;
  logic        synced_o;
  logic        underrun_o;
  logic        sof_err_o;
  logic        eol_err_o;

  typedef struct {
    logic [15:0] data;
    logic        user;
    logic        last;
    int          idle;
  } beat_t;

  beat_t      beatQ[$];
  logic [7:0] expQ[$];
  int         checkCount = 0;
  int         errCount = 0;
  int         byteIdx = 0;
  logic       hsSeen;
  logic       enAtEdge;

  bt656_stream_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .enable_i(enable_i), .err_clr_i(err_clr_i),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tuser(s_tuser), .s_tlast(s_tlast), .bt656_data_o(bt656_data_o),
    .synced_o(synced_o), .underrun_o(underrun_o), .sof_err_o(sof_err_o),
    .eol_err_o(eol_err_o)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [7:0] clampB(input logic [7:0] v);
    if (v == 8'h00) return 8'h01;
    if (v == 8'hFF) return 8'hFE;
    return v;
  endfunction

  // One line of expected bytes; slot bit 16 marks a pixel that should reach the output.
  function automatic void pushLine(input bit act, input logic [3:0][16:0] s);
    expQ.push_back(8'hFF); expQ.push_back(8'h00); expQ.push_back(8'h00);
    expQ.push_back(act ? 8'h9D : 8'hB6);
    for (int j = 0; j < HB; j++) expQ.push_back((j % 2 == 0) ? 8'h80 : 8'h10);
    expQ.push_back(8'hFF); expQ.push_back(8'h00); expQ.push_back(8'h00);
    expQ.push_back(act ? 8'h80 : 8'hAB);
    for (int p = 0; p < HA; p++) begin
      if (act && s[p][16]) begin
        expQ.push_back(clampB(s[p][15:8]));
        expQ.push_back(clampB(s[p][7:0]));
      end else begin
        expQ.push_back(8'h80);
        expQ.push_back(8'h10);
      end
    end
  endfunction

  // Output frames begin at the blank line, then active lines 0 and 1.
  function automatic void pushFrame(input logic [7:0][16:0] s);
    pushLine(1'b0, '0);
    pushLine(1'b1, s[3:0]);
    pushLine(1'b1, s[7:4]);
  endfunction

  function automatic void pushBeat(input logic [15:0] d, input logic u, input logic l, input int idle);
    beat_t b;
    b.data = d; b.user = u; b.last = l; b.idle = idle;
    beatQ.push_back(b);
  endfunction

  function automatic void queueNormal(input logic [7:0][15:0] d, input bit dropLast3);
    logic [7:0][16:0] s;
    for (int i = 0; i < 8; i++) begin
      pushBeat(d[i], i == 0, (i == 3 && !dropLast3) || i == 7, 0);
      s[i] = {1'b1, d[i]};
    end
    pushFrame(s);
  endfunction

  function automatic logic [7:0][15:0] randFrame();
    logic [7:0][15:0] d;
    for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
    return d;
  endfunction

  task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic sy, input logic un, input logic so, input logic eo);
    checkEq({tag, "_synced"}, 16'(synced_o), 16'(sy));
    checkEq({tag, "_underrun"}, 16'(underrun_o), 16'(un));
    checkEq({tag, "_sof"}, 16'(sof_err_o), 16'(so));
    checkEq({tag, "_eol"}, 16'(eol_err_o), 16'(eo));
  endtask

  task automatic checkOutput();
    logic [7:0] exp;
    if (enAtEdge) begin
      checkCount++;
      assert (expQ.size() > 0) else begin
        errCount++;
        $error("[TB] FAIL exp_avail: observed=%h expected=model byte", bt656_data_o);
      end
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        checkEq($sformatf("byte%0d", byteIdx), {8'h00, bt656_data_o}, {8'h00, exp});
      end
      byteIdx++;
    end else begin
      checkEq("idle_byte", {8'h00, bt656_data_o}, 16'h0010);
      checkEq("idle_ready", 16'(s_tready), 16'd0);
    end
  endtask

  task automatic applyStimulus();
    beat_t b;
    @(negedge ACLK);
    s_tvalid = 1'b0; s_tdata = 16'h0000; s_tuser = 1'b0; s_tlast = 1'b0;
    if (beatQ.size() > 0) begin
      b = beatQ[0];
      if (b.idle > 0) begin
        b.idle--;
        beatQ[0] = b;
      end else begin
        s_tvalid = 1'b1; s_tdata = b.data; s_tuser = b.user; s_tlast = b.last;
      end
    end
    #1;
    hsSeen   = s_tvalid && s_tready;
    enAtEdge = enable_i && ARESETn;
    @(posedge ACLK);
    if (hsSeen) void'(beatQ.pop_front());
    #1;
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    logic [7:0][15:0] d;
    logic [7:0][15:0] h;
    logic [7:0][16:0] s;

    ARESETn = 1'b0; enable_i = 1'b0; err_clr_i = 1'b0;
    s_tvalid = 1'b0; s_tdata = 16'h0000; s_tuser = 1'b0; s_tlast = 1'b0;

    runCycles(3);
    ARESETn = 1'b1;
    runCycles(10);
    checkFlags("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] enable with no input");
    enable_i = 1'b1;
    pushFrame('0);
    runCycles(60);
    checkFlags("noinput", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] full frames");
    d = {16'hF011, 16'hDDEE, 16'hBBCC, 16'h99AA, 16'h7788, 16'h5566, 16'h3344, 16'h1122};
    queueNormal(d, 1'b0);
    runCycles(60);
    checkFlags("frame1", 1'b1, 1'b0, 1'b0, 1'b0);
    d = randFrame();
    d[1] = 16'h00FF;
    d[5] = 16'hFF00;
    queueNormal(d, 1'b0);
    runCycles(60);
    checkFlags("frame2", 1'b1, 1'b0, 1'b0, 1'b0);
    queueNormal(randFrame(), 1'b0);
    runCycles(60);
    checkFlags("frame3", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] underrun");
    d = randFrame();
    pushBeat(d[0], 1'b1, 1'b0, 0);
    pushBeat(d[1], 1'b0, 1'b0, 0);
    pushBeat(d[4], 1'b0, 1'b0, 8);
    pushBeat(d[5], 1'b0, 1'b0, 0);
    pushBeat(d[6], 1'b0, 1'b0, 0);
    pushBeat(d[7], 1'b0, 1'b1, 0);
    s = '0;
    s[0] = {1'b1, d[0]}; s[1] = {1'b1, d[1]};
    for (int i = 4; i < 8; i++) s[i] = {1'b1, d[i]};
    pushFrame(s);
    runCycles(60);
    checkFlags("underrun", 1'b1, 1'b1, 1'b0, 1'b0);
    queueNormal(randFrame(), 1'b0);
    err_clr_i = 1'b1;
    runCycles(1);
    err_clr_i = 1'b0;
    checkEq("underrun_clr", 16'(underrun_o), 16'd0);
    runCycles(59);
    checkFlags("after_clr", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] missing end of line");
    queueNormal(randFrame(), 1'b1);
    runCycles(60);
    checkFlags("eol", 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] early start of frame");
    d = randFrame();
    h = randFrame();
    pushBeat(d[0], 1'b1, 1'b0, 0);
    pushBeat(d[1], 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) pushBeat(h[i], i == 0, i == 3 || i == 7, 0);
    s = '0;
    s[0] = {1'b1, d[0]}; s[1] = {1'b1, d[1]};
    pushFrame(s);
    for (int i = 0; i < 8; i++) s[i] = {1'b1, h[i]};
    pushFrame(s);
    err_clr_i = 1'b1;
    runCycles(1);
    err_clr_i = 1'b0;
    checkEq("eol_clr", 16'(eol_err_o), 16'd0);
    runCycles(59);
    checkFlags("sof", 1'b0, 1'b0, 1'b1, 1'b0);
    runCycles(20);
    checkEq("sof_wait_synced", 16'(synced_o), 16'd0);
    runCycles(40);
    checkFlags("resync", 1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset mid-frame");
    queueNormal(randFrame(), 1'b0);
    runCycles(30);
    checkEq("pre_reset_synced", 16'(synced_o), 16'd1);
    #1;
    ARESETn = 1'b0;
    #1;
    checkEq("async_byte", {8'h00, bt656_data_o}, 16'h0010);
    checkEq("async_ready", 16'(s_tready), 16'd0);
    checkFlags("async", 1'b0, 1'b0, 1'b0, 1'b0);
    enable_i = 1'b0;
    beatQ.delete();
    expQ.delete();
    runCycles(2);
    ARESETn = 1'b1;
    enable_i = 1'b1;
    pushFrame('0);
    runCycles(60);
    checkFlags("restart", 1'b0, 1'b0, 1'b0, 1'b0);
    queueNormal(randFrame(), 1'b0);
    runCycles(60);
    checkFlags("restart_sync", 1'b1, 1'b0, 1'b0, 1'b0);
    checkEq("exp_drained", 16'(expQ.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
